thor2023_dcache_fill: RTL and testbench

Data-cache line-fill engine for the Thor2023 memory unit. On a cache miss it fetches one full cache line from the system bus as a sequence of bus-width beats and assembles the line. It then presents the line to the data-cache arrays with a single-cycle `wr_dc` strobe. It also owns the pseudo-random replacement LFSR whose low bits the write-way selector uses as the victim way during that strobe, making it the producing end of the `wr_dc`/`lfsr` interface.

---
 rtl/thor2023_dcache_fill.sv | 102 ++++++++++
 tb/tb_thor2023_dcache_fill.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/thor2023_dcache_fill.sv
// Data-cache line-fill engine: fetches one line as BEATS linear bus beats, then strobes wr_dc once.
// Latency: miss accepted -> wr_dc in 1+BEATS cycles plus bus wait states; the bus side holds cyc until the last ack or err.
module thor2023_dcache_fill #(
    parameter int LINE_BYTES = 64,
    parameter int BUS_BYTES  = 16,
    parameter int ABITS      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dce,
    input  logic                    miss,
    input  logic [ABITS-1:0]        miss_adr,
    output logic                    miss_ack,
    output logic                    cyc,
    output logic                    stb,
    output logic [ABITS-1:0]        adr,
    input  logic                    ack,
    input  logic                    err,
    input  logic [8*BUS_BYTES-1:0]  dat_i,
    output logic [8*LINE_BYTES-1:0] line,
    output logic [ABITS-1:0]        wadr,
    output logic                    wr_dc,
    output logic [1:0]              lfsr,
    output logic                    busy,
    output logic                    fill_err
);
    localparam int BEATS = LINE_BYTES / BUS_BYTES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = 8 * BUS_BYTES;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [ABITS-1:0] LINE_MASK = ABITS'(LINE_BYTES - 1);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);

    logic [1:0]    state;
    logic [BW-1:0] beat;
    logic [15:0]   lfsr_q;
    logic          fb;

    assign fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr = lfsr_q[1:0];
    assign stb  = cyc;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            beat     <= '0;
            cyc      <= 1'b0;
            miss_ack <= 1'b0;
            wr_dc    <= 1'b0;
            fill_err <= 1'b0;
            adr      <= '0;
            wadr     <= '0;
            line     <= '0;
            lfsr_q   <= 16'hACE1;
        end else begin
            miss_ack <= 1'b0;
            wr_dc    <= 1'b0;
            fill_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (miss && dce) begin
                        state    <= ST_FETCH;
                        wadr     <= miss_adr & ~LINE_MASK;
                        adr      <= miss_adr & ~LINE_MASK;
                        beat     <= '0;
                        cyc      <= 1'b1;
                        miss_ack <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // After an abort the bus is already released; spend one cycle here before IDLE.
                    if (!cyc) begin
                        state <= ST_IDLE;
                    end else if (err) begin
                        cyc      <= 1'b0;
                        fill_err <= 1'b1;
                    end else if (ack) begin
                        line[int'(beat)*DW +: DW] <= dat_i;
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            cyc   <= 1'b0;
                            wr_dc <= 1'b1;
                            state <= ST_WRITE;
                        end else begin
                            adr <= adr + ABITS'(BUS_BYTES);
                        end
                    end
                end
                ST_WRITE: begin
                    state  <= ST_IDLE;
                    lfsr_q <= {lfsr_q[14:0], fb};
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_thor2023_dcache_fill.sv
// Directed bench for thor2023_dcache_fill: fills with and without wait states, abort, dce gating, mid-fill reset.
module tb_thor2023_dcache_fill;
    logic         clk = 1'b0;
    logic         rst;
    logic         dce;
    logic         miss;
    logic [31:0]  miss_adr;
    logic         miss_ack;
    logic         cyc;
    logic         stb;
    logic [31:0]  adr;
    logic         ack;
    logic         err;
    logic [127:0] dat_i;
    logic [511:0] line;
    logic [31:0]  wadr;
    logic         wr_dc;
    logic [1:0]   lfsr;
    logic         busy;
    logic         fill_err;

    int n_checks = 0;
    int n_errors = 0;
    int waits[4];

    always #5 clk = ~clk;

    thor2023_dcache_fill dut (
        .clk      (clk),
        .rst      (rst),
        .dce      (dce),
        .miss     (miss),
        .miss_adr (miss_adr),
        .miss_ack (miss_ack),
        .cyc      (cyc),
        .stb      (stb),
        .adr      (adr),
        .ack      (ack),
        .err      (err),
        .dat_i    (dat_i),
        .line     (line),
        .wadr     (wadr),
        .wr_dc    (wr_dc),
        .lfsr     (lfsr),
        .busy     (busy),
        .fill_err (fill_err)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one fill from the miss edge to the wr_dc cycle, using waits[] per beat.
    task automatic do_fill(input logic [31:0] a, input logic [1:0] exp_lfsr, input bit drop_dce);
        logic [511:0] exp_line;
        logic [127:0] d;
        logic [31:0]  base;
        exp_line = '0;
        base     = a & 32'hFFFF_FFC0;
        miss_adr = a;
        miss     = 1'b1;
        tick();
        miss = 1'b0;
        if (drop_dce) dce = 1'b0;
        check("miss_ack", miss_ack, 1'b1);
        check("cyc_start", cyc, 1'b1);
        check("busy_fetch", busy, 1'b1);
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < waits[b]; w++) begin
                check("cyc_wait", cyc, 1'b1);
                check("adr_wait", adr, base + 32'(16 * b));
                tick();
            end
            check("adr", adr, base + 32'(16 * b));
            check("stb", stb, 1'b1);
            d = {$urandom, $urandom, $urandom, $urandom};
            exp_line[b*128 +: 128] = d;
            dat_i = d;
            ack   = 1'b1;
            tick();
            ack   = 1'b0;
            dat_i = '0;
            if (b < 3) check("no_early_wr", wr_dc, 1'b0);
        end
        check("wr_dc", wr_dc, 1'b1);
        check("cyc_write", cyc, 1'b0);
        check("wadr", wadr, base);
        check("line", line, exp_line);
        check("lfsr_write", lfsr, exp_lfsr);
        dce = 1'b1;
    endtask

    initial begin
        logic seen;
        rst = 1'b0; dce = 1'b0; miss = 1'b0; miss_adr = '0;
        ack = 1'b0; err = 1'b0; dat_i = '0;
        tick(); tick();
        check("rst_cyc", cyc, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_lfsr", lfsr, 2'b01);
        check("rst_line", line, '0);
        check("rst_wadr", wadr, '0);
        check("rst_adr", adr, '0);
        check("rst_wr_dc", wr_dc, 1'b0);
        rst = 1'b1;
        dce = 1'b1;
        tick();

        // Zero-wait fill, then a back-to-back one.
        waits = '{0, 0, 0, 0};
        do_fill(32'h0000_1234, 2'b01, 1'b0);
        tick();
        check("gap_busy", busy, 1'b0);
        check("gap_wr_dc", wr_dc, 1'b0);
        do_fill(32'hFFFF_FFC5, 2'b11, 1'b0);
        tick();
        check("idle_after2", busy, 1'b0);

        // Wait states per beat; LFSR is 16'hB387 here.
        waits = '{2, 0, 3, 1};
        do_fill(32'h0040_0088, 2'b11, 1'b0);
        tick();
        check("wr_dc_once", wr_dc, 1'b0);

        // Error on beat 2 coincident with ack.
        rst = 1'b0; tick(); rst = 1'b1;
        miss_adr = 32'h0000_2000; miss = 1'b1;
        tick();
        miss = 1'b0;
        for (int b = 0; b < 2; b++) begin
            ack = 1'b1; dat_i = {4{32'(b + 1)}};
            tick();
        end
        err = 1'b1;
        tick();
        ack = 1'b0; err = 1'b0;
        check("err_fill_err", fill_err, 1'b1);
        check("err_cyc", cyc, 1'b0);
        check("err_wr_dc", wr_dc, 1'b0);
        check("err_busy", busy, 1'b1);
        tick();
        check("err_pulse_end", fill_err, 1'b0);
        check("err_idle", busy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= wr_dc;
            tick();
        end
        check("err_no_wr_dc", seen, 1'b0);
        check("err_lfsr", lfsr, 2'b01);

        // Miss held with dce low, then dce rises; dce drops mid-fill.
        dce = 1'b0; miss = 1'b1; miss_adr = 32'h0000_3000;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= miss_ack | cyc | busy;
        end
        check("dce_off_idle", seen, 1'b0);
        dce = 1'b1;
        waits = '{0, 1, 0, 0};
        do_fill(32'h0000_3010, 2'b01, 1'b1);
        tick();

        // Reset during beat 1.
        miss_adr = 32'h0000_5000; miss = 1'b1;
        tick();
        miss = 1'b0;
        ack = 1'b1; dat_i = {4{32'hDEAD_BEEF}};
        tick();
        check("rst_mid_beat1", adr, 32'h0000_5010);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_mid_cyc", cyc, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_lfsr", lfsr, 2'b01);
        check("rst_mid_line", line, '0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= wr_dc | cyc;
        end
        ack = 1'b0;
        check("rst_mid_no_wr", seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
